// File: rtl/game_flow_fsm.sv
// Top-level game sequencer: start screen, per-round intro, gameplay, game over.
// Drives one-hot screen enables and round information for the renderers.
module game_flow_fsm #(
    parameter int N_ROUNDS          = 3,
    parameter int BTN_X             = 384,
    parameter int BTN_Y             = 300,
    parameter int BTN_W             = 256,
    parameter int BTN_H             = 64,
    parameter int INTRO_CYCLES      = 65000000,
    parameter int GO_HOLD_CYCLES    = 32500000,
    parameter int GO_TIMEOUT_CYCLES = 650000000,
    localparam int RW = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          left_mouse,
    input  logic [11:0]   mouse_xpos,
    input  logic [11:0]   mouse_ypos,
    input  logic          round_done,
    input  logic          game_lost,
    output logic          start_screen_enable,
    output logic          intro_enable,
    output logic          game_enable,
    output logic          game_end_enable,
    output logic [RW-1:0] round_idx,
    output logic          round_start,
    output logic          last_round
);

    localparam int TMAX = (INTRO_CYCLES > GO_TIMEOUT_CYCLES) ?
                          INTRO_CYCLES : GO_TIMEOUT_CYCLES;
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [1:0] START     = 2'd0;
    localparam logic [1:0] INTRO     = 2'd1;
    localparam logic [1:0] RUNNING   = 2'd2;
    localparam logic [1:0] GAME_OVER = 2'd3;

    localparam logic [TW-1:0] T_INTRO_END = TW'(INTRO_CYCLES - 1);
    localparam logic [TW-1:0] T_HOLD      = TW'(GO_HOLD_CYCLES);
    localparam logic [TW-1:0] T_GO_END    = TW'(GO_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST      = RW'(N_ROUNDS - 1);

    // 13-bit bounds so BTN_X+BTN_W cannot wrap at the 12-bit screen edge
    localparam logic [12:0] BX0 = 13'(BTN_X);
    localparam logic [12:0] BX1 = 13'(BTN_X + BTN_W);
    localparam logic [12:0] BY0 = 13'(BTN_Y);
    localparam logic [12:0] BY1 = 13'(BTN_Y + BTN_H);

    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_d;
    logic [RW-1:0] round_d;
    logic          round_start_d;
    logic          left_mouse_q;
    logic          click;
    logic          in_btn;
    logic [12:0]   x13;
    logic [12:0]   y13;

    assign x13    = {1'b0, mouse_xpos};
    assign y13    = {1'b0, mouse_ypos};
    assign in_btn = (x13 >= BX0) && (x13 < BX1) &&
                    (y13 >= BY0) && (y13 < BY1);
    assign click  = left_mouse & ~left_mouse_q;

    assign last_round = (round_idx == R_LAST);

    always_comb begin
        state_d       = state;
        timer_d       = timer;
        round_d       = round_idx;
        round_start_d = 1'b0;
        case (state)
            START: begin
                timer_d = '0;
                if (click && in_btn) begin
                    state_d = INTRO;
                    round_d = '0;
                end
            end
            INTRO: begin
                if (timer == T_INTRO_END) begin
                    state_d       = RUNNING;
                    timer_d       = '0;
                    round_start_d = 1'b1;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            RUNNING: begin
                timer_d = '0;
                if (game_lost) begin
                    state_d = GAME_OVER;
                end else if (round_done) begin
                    if (last_round) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d = INTRO;
                        round_d = round_idx + RW'(1);
                    end
                end
            end
            GAME_OVER: begin
                // leaving at T_GO_END means the timer never passes it
                if ((click && timer >= T_HOLD) || timer == T_GO_END) begin
                    state_d = START;
                    timer_d = '0;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: begin
                state_d = START;
                timer_d = '0;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= START;
            timer        <= '0;
            round_idx    <= '0;
            round_start  <= 1'b0;
            left_mouse_q <= 1'b1;
        end else begin
            state        <= state_d;
            timer        <= timer_d;
            round_idx    <= round_d;
            round_start  <= round_start_d;
            left_mouse_q <= left_mouse;
        end
    end

    assign start_screen_enable = (state == START);
    assign intro_enable        = (state == INTRO);
    assign game_enable         = (state == RUNNING);
    assign game_end_enable     = (state == GAME_OVER);

endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: directed plan steps, then random play
// checked every cycle against a screen/age reference model.
module tb_game_flow_fsm;

    localparam int NR = 2;
    localparam int IC = 4;
    localparam int HC = 5;
    localparam int TC = 20;
    localparam int RW = 1;

    localparam int S_START = 0;
    localparam int S_INTRO = 1;
    localparam int S_RUN   = 2;
    localparam int S_OVER  = 3;

    logic          clk;
    logic          rst_n;
    logic          left_mouse;
    logic [11:0]   mouse_xpos;
    logic [11:0]   mouse_ypos;
    logic          round_done;
    logic          game_lost;
    logic          start_screen_enable;
    logic          intro_enable;
    logic          game_enable;
    logic          game_end_enable;
    logic [RW-1:0] round_idx;
    logic          round_start;
    logic          last_round;

    int total;
    int fails;

    int m_scr;
    int m_age;
    int m_round;
    bit m_prev;
    bit m_rs;

    game_flow_fsm #(
        .N_ROUNDS(NR),
        .BTN_X(384),
        .BTN_Y(300),
        .BTN_W(256),
        .BTN_H(64),
        .INTRO_CYCLES(IC),
        .GO_HOLD_CYCLES(HC),
        .GO_TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .left_mouse(left_mouse),
        .mouse_xpos(mouse_xpos),
        .mouse_ypos(mouse_ypos),
        .round_done(round_done),
        .game_lost(game_lost),
        .start_screen_enable(start_screen_enable),
        .intro_enable(intro_enable),
        .game_enable(game_enable),
        .game_end_enable(game_end_enable),
        .round_idx(round_idx),
        .round_start(round_start),
        .last_round(last_round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_scr   = S_START;
        m_age   = 0;
        m_round = 0;
        m_prev  = 1'b1;
        m_rs    = 1'b0;
    endtask

    // Screen-level view: which screen, how long it has been up,
    // and which round is shown.
    task automatic model_step(input bit lm, input int x,
                              input int y, input bit rd,
                              input bit gl);
        bit click;
        bit inb;
        click  = lm && !m_prev;
        m_prev = lm;
        inb    = (x >= 384) && (x < 640) &&
                 (y >= 300) && (y < 364);
        m_rs   = 1'b0;
        case (m_scr)
            S_START: if (click && inb) begin
                m_scr   = S_INTRO;
                m_round = 0;
                m_age   = 0;
            end
            S_INTRO: begin
                if (m_age + 1 == IC) begin
                    m_scr = S_RUN;
                    m_age = 0;
                    m_rs  = 1'b1;
                end else m_age++;
            end
            S_RUN: begin
                if (gl || (rd && m_round == NR - 1)) begin
                    m_scr = S_OVER;
                end else if (rd) begin
                    m_round++;
                    m_scr = S_INTRO;
                end
                m_age = 0;
            end
            default: begin
                if ((click && m_age >= HC) || m_age == TC - 1) begin
                    m_scr = S_START;
                    m_age = 0;
                end else m_age++;
            end
        endcase
    endtask

    task automatic check_model();
        chk("start_en", 32'(start_screen_enable),
            32'(m_scr == S_START));
        chk("intro_en", 32'(intro_enable), 32'(m_scr == S_INTRO));
        chk("game_en", 32'(game_enable), 32'(m_scr == S_RUN));
        chk("end_en", 32'(game_end_enable), 32'(m_scr == S_OVER));
        chk("round_idx", 32'(round_idx), 32'(m_round));
        chk("round_start", 32'(round_start), 32'(m_rs));
        chk("last_round", 32'(last_round),
            32'(m_round == NR - 1));
    endtask

    task automatic drive(input bit lm, input int x, input int y,
                         input bit rd, input bit gl);
        left_mouse = lm;
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        round_done = rd;
        game_lost  = gl;
        model_step(lm, x, y, rd, gl);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic click_at(input int x, input int y);
        drive(1, x, y, 0, 0);
        drive(0, x, y, 0, 0);
    endtask

    initial begin
        total      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        left_mouse = 1'b1;
        mouse_xpos = 12'd400;
        mouse_ypos = 12'd310;
        round_done = 1'b0;
        game_lost  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_en", 32'(start_screen_enable), 32'd1);
        chk("rst_end_en", 32'(game_end_enable), 32'd0);
        chk("rst_round", 32'(round_idx), 32'd0);
        chk("rst_rs", 32'(round_start), 32'd0);
        rst_n = 1'b1;

        // button held through reset release
        for (int i = 0; i < 10; i++) begin
            drive(1, 400, 310, 0, 0);
            chk("held_start", 32'(start_screen_enable), 32'd1);
        end
        drive(0, 400, 310, 0, 0);
        drive(1, 400, 310, 0, 0);
        chk("press_intro", 32'(intro_enable), 32'd1);
        drive(0, 400, 310, 0, 0);
        idle(2);
        chk("intro_4th", 32'(intro_enable), 32'd1);
        idle(1);
        chk("run_r0", 32'(game_enable), 32'd1);
        chk("rs_pulse", 32'(round_start), 32'd1);
        idle(1);
        chk("rs_width", 32'(round_start), 32'd0);
        drive(0, 0, 0, 1, 0);
        chk("intro_r1", 32'(intro_enable), 32'd1);
        chk("last_r1", 32'(last_round), 32'd1);
        idle(4);
        drive(0, 0, 0, 1, 0);
        chk("over_r1", 32'(game_end_enable), 32'd1);
        chk("over_round", 32'(round_idx), 32'd1);

        // click lockout then accepted click
        idle(3);
        drive(1, 0, 0, 0, 0);
        chk("lockout", 32'(game_end_enable), 32'd1);
        drive(0, 0, 0, 0, 0);
        idle(1);
        drive(1, 0, 0, 0, 0);
        chk("go_click", 32'(start_screen_enable), 32'd1);
        drive(0, 0, 0, 0, 0);

        // hit-box boundaries
        click_at(383, 310);
        click_at(640, 310);
        click_at(400, 364);
        chk("outside", 32'(start_screen_enable), 32'd1);
        drive(1, 384, 300, 0, 0);
        chk("corner_lo", 32'(intro_enable), 32'd1);
        drive(0, 384, 300, 0, 0);
        idle(3);
        drive(0, 0, 0, 0, 1);
        chk("lost", 32'(game_end_enable), 32'd1);
        idle(19);
        chk("pre_timeout", 32'(game_end_enable), 32'd1);
        idle(1);
        chk("timeout", 32'(start_screen_enable), 32'd1);
        drive(1, 639, 363, 0, 0);
        chk("corner_hi", 32'(intro_enable), 32'd1);
        drive(0, 639, 363, 0, 0);
        idle(3);

        // lost wins over done
        drive(0, 0, 0, 1, 1);
        chk("prio_over", 32'(game_end_enable), 32'd1);
        chk("prio_round", 32'(round_idx), 32'd0);
        idle(20);

        // async reset mid round 1
        click_at(500, 320);
        idle(3);
        drive(0, 0, 0, 1, 0);
        idle(4);
        chk("run_r1", 32'(game_enable), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_start", 32'(start_screen_enable), 32'd1);
        chk("arst_game", 32'(game_enable), 32'd0);
        chk("arst_round", 32'(round_idx), 32'd0);
        chk("arst_rs", 32'(round_start), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom % 2),
                  370 + int'($urandom % 290),
                  290 + int'($urandom % 90),
                  1'($urandom % 6 == 0),
                  1'($urandom % 14 == 0));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
